// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with 128-bit lines, LRU replacement,
// a blocking single-line refill path and saturating hit/miss counters.
module icache_2way #(
    parameter int unsigned INDEX_W    = 7,
    parameter int unsigned MISS_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [31:0]           ADDR,
    input  logic                  flush,
    output logic [31:0]           DO,
    output logic                  cache_stall_n,
    output logic                  IREQ,
    output logic [31:0]           IADDR,
    input  logic                  IACK,
    input  logic [127:0]          data_in,
    output logic [MISS_CNT_W-1:0] hit_cnt,
    output logic [MISS_CNT_W-1:0] miss_cnt
);

    localparam int unsigned SETS   = 2 ** INDEX_W;
    localparam int unsigned TAG_W  = 32 - INDEX_W - 4;
    localparam int unsigned LINE_W = 128;
    localparam logic [MISS_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state;
    state_t state_next;

    logic [TAG_W-1:0]   tag_mem0  [SETS];
    logic [TAG_W-1:0]   tag_mem1  [SETS];
    logic [LINE_W-1:0]  data_mem0 [SETS];
    logic [LINE_W-1:0]  data_mem1 [SETS];
    logic [SETS-1:0]    valid0;
    logic [SETS-1:0]    valid1;
    logic [SETS-1:0]    lru;

    logic [TAG_W-1:0]   miss_tag;
    logic [INDEX_W-1:0] miss_index;
    logic               flush_pending;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [1:0]         addr_off;
    logic               addr_unused;

    logic               hit0;
    logic               hit1;
    logic               lookup_hit;
    logic               lookup_miss;
    logic               hit_way;
    logic               fill_done;
    logic               victim;
    logic               flush_now;
    logic [31:0]        hit_word;
    logic [31:0]        fill_word;

    function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line, input logic [1:0] off);
        logic [31:0] w;
        case (off)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            default: w = line[127:96];
        endcase
        return w;
    endfunction

    // Address decode; byte-within-word bits are irrelevant to a word fetch.
    assign addr_tag    = ADDR[31:INDEX_W+4];
    assign addr_index  = ADDR[INDEX_W+3:4];
    assign addr_off    = ADDR[3:2];
    assign addr_unused = ^ADDR[1:0];

    assign hit0 = valid0[addr_index] && (tag_mem0[addr_index] == addr_tag);
    assign hit1 = valid1[addr_index] && (tag_mem1[addr_index] == addr_tag);

    assign hit_word  = word_sel(hit_way ? data_mem1[addr_index] : data_mem0[addr_index], addr_off);
    assign fill_word = word_sel(data_in, addr_off);

    // Prefer an empty way, otherwise evict the least-recently-used one.
    always_comb begin
        victim = 1'b0;
        if (valid0[miss_index]) begin
            victim = valid1[miss_index] ? lru[miss_index] : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next    = state;
        lookup_hit    = 1'b0;
        lookup_miss   = 1'b0;
        hit_way       = 1'b0;
        fill_done     = 1'b0;
        IREQ          = 1'b0;
        cache_stall_n = 1'b1;
        IADDR         = {ADDR[31:4], 4'b0000};
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit0 || hit1) begin
                        lookup_hit = 1'b1;
                        hit_way    = !hit0;
                    end else begin
                        lookup_miss   = 1'b1;
                        cache_stall_n = 1'b0;
                        state_next    = FILL;
                    end
                end
            end
            FILL: begin
                IREQ          = 1'b1;
                cache_stall_n = 1'b0;
                IADDR         = {miss_tag, miss_index, 4'b0000};
                if (IACK) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A flush seen during a fill is deferred until the line has landed.
    assign flush_now = ((state == IDLE) && flush) || (fill_done && (flush || flush_pending));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid0        <= '0;
            valid1        <= '0;
            lru           <= '0;
            flush_pending <= 1'b0;
            DO            <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            if (lookup_hit) begin
                DO              <= hit_word;
                lru[addr_index] <= !hit_way;
                if (hit_cnt != CNT_MAX) begin
                    hit_cnt <= hit_cnt + MISS_CNT_W'(1);
                end
            end
            if (lookup_miss && (miss_cnt != CNT_MAX)) begin
                miss_cnt <= miss_cnt + MISS_CNT_W'(1);
            end
            if (fill_done) begin
                if (victim) begin
                    valid1[miss_index] <= 1'b1;
                end else begin
                    valid0[miss_index] <= 1'b1;
                end
                lru[miss_index] <= !victim;
                DO              <= fill_word;
            end
            if ((state == FILL) && flush && !fill_done) begin
                flush_pending <= 1'b1;
            end
            if (flush_now) begin
                valid0        <= '0;
                valid1        <= '0;
                lru           <= '0;
                flush_pending <= 1'b0;
            end
        end
    end

    // Miss capture and line storage; contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (lookup_miss) begin
            miss_tag   <= addr_tag;
            miss_index <= addr_index;
        end
        if (fill_done) begin
            if (victim) begin
                tag_mem1[miss_index]  <= miss_tag;
                data_mem1[miss_index] <= data_in;
            end else begin
                tag_mem0[miss_index]  <= miss_tag;
                data_mem0[miss_index] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_icache_2way.sv
// Randomized scoreboard bench for icache_2way: a recency-list model of each set
// predicts every DO word and the performance counters.
module tb_icache_2way;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic [31:0]  ADDR;
    logic         flush;
    logic         IACK;
    logic [127:0] data_in;
    logic [31:0]  DO;
    logic         cache_stall_n;
    logic         IREQ;
    logic [31:0]  IADDR;
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;
    logic [31:0]  s_do;
    logic         s_stall_n;
    logic         s_ireq;
    logic [31:0]  s_iaddr;
    logic [3:0]   s_hit;
    logic [3:0]   s_miss;

    always #5 clk = ~clk;

    icache_2way #(.INDEX_W(7), .MISS_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ADDR(ADDR), .flush(flush),
        .DO(DO), .cache_stall_n(cache_stall_n), .IREQ(IREQ), .IADDR(IADDR),
        .IACK(IACK), .data_in(data_in), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    icache_2way #(.INDEX_W(7), .MISS_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .ADDR(ADDR), .flush(flush),
        .DO(s_do), .cache_stall_n(s_stall_n), .IREQ(s_ireq), .IADDR(s_iaddr),
        .IACK(IACK), .data_in(data_in), .hit_cnt(s_hit), .miss_cnt(s_miss)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_q [$];
    int          n_ways   [128];
    logic [31:0] mru_line [128];
    logic [31:0] lru_line [128];
    int          exp_hit;
    int          exp_miss;

    logic [31:0] cur_line;
    int          fixed_delay = -1;
    bit          mem_en      = 1'b0;
    bit          stray_en    = 1'b0;
    int          late_req    = 0;
    int          late_done   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] line, input int k);
        return (line * 32'h9E37_79B1) ^ (32'(k) * 32'h1357_9BDF) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] line);
        return {mem_word(line, 3), mem_word(line, 2), mem_word(line, 1), mem_word(line, 0)};
    endfunction

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 128; i++) n_ways[i] = 0;
    endfunction

    // Each set is a most-recent-first list of at most two line addresses.
    function automatic bit model_lookup(input logic [31:0] line);
        int s;
        s = int'(line[10:4]);
        if (n_ways[s] >= 1 && mru_line[s] == line) return 1'b1;
        if (n_ways[s] == 2 && lru_line[s] == line) begin
            lru_line[s] = mru_line[s];
            mru_line[s] = line;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_insert(input logic [31:0] line);
        int s;
        s = int'(line[10:4]);
        if (n_ways[s] >= 1) lru_line[s] = mru_line[s];
        mru_line[s] = line;
        if (n_ways[s] < 2) n_ways[s]++;
    endfunction

    task automatic check_counters();
        check("hit_cnt",      32'(hit_cnt),  32'(exp_hit));
        check("miss_cnt",     32'(miss_cnt), 32'(exp_miss));
        check("hit_cnt_sat",  32'(s_hit),    32'(sat4(exp_hit)));
        check("miss_cnt_sat", 32'(s_miss),   32'(sat4(exp_miss)));
    endtask

    // CPU side: present ADDR until the cache stops stalling, optionally flushing mid-fill.
    task automatic access(input logic [31:0] addr, input bit mid_flush, output int cycles);
        logic [31:0] line;
        logic [31:0] w;
        bit          hit;
        bit          done;
        bit          fl_done;
        bit          s;
        line     = {addr[31:4], 4'b0000};
        w        = mem_word(line, int'(addr[3:2]));
        cur_line = line;
        hit      = model_lookup(line);
        if (hit) begin
            exp_hit++;
            exp_q.push_back(w);
        end else begin
            exp_miss++;
            exp_q.push_back(w);
            if (mid_flush) begin
                model_clear();
                exp_miss++;
                exp_q.push_back(w);
            end
            model_insert(line);
            exp_hit++;
            exp_q.push_back(w);
        end
        req     = 1'b1;
        ADDR    = addr;
        done    = 1'b0;
        fl_done = 1'b0;
        cycles  = 0;
        while (!done && cycles < 80) begin
            #1;
            if (mid_flush && !hit && !fl_done && IREQ) begin
                flush   = 1'b1;
                fl_done = 1'b1;
            end
            s = cache_stall_n;
            @(negedge clk);
            flush = 1'b0;
            cycles++;
            if (s) done = 1'b1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles", addr, cycles);
        end
        req = 1'b0;
        check_counters();
    endtask

    task automatic flush_idle();
        req   = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 4)
          | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_E000);
        return a;
    endfunction

    // Memory: answer fills after a delay; also emit stray IACKs while idle.
    initial begin
        int d;
        IACK    = 1'b0;
        data_in = '0;
        forever begin
            @(negedge clk);
            if (mem_en && IREQ) begin
                check("iaddr", IADDR, cur_line);
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                repeat (d) @(negedge clk);
                IACK    = 1'b1;
                data_in = mem_line(cur_line);
                @(negedge clk);
                IACK    = 1'b0;
                data_in = {$urandom, $urandom, $urandom, $urandom};
            end else if (!IREQ && ((late_req != late_done) || (stray_en && $urandom_range(0, 7) == 0))) begin
                if (late_req != late_done) late_done++;
                IACK    = 1'b1;
                data_in = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                IACK    = 1'b0;
            end
        end
    end

    // Monitor: a DO word is produced on a hit edge or on a fill-completion edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1 && ((req && cache_stall_n) || (IREQ && IACK))) begin
                #1;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL do_unexpected: got %h with no word expected at %0t", DO, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("do", DO, e);
                    check("do_sat", s_do, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int op;
        rst_n = 1'b0;
        req   = 1'b0;
        flush = 1'b0;
        ADDR  = '0;
        model_clear();
        exp_hit  = 0;
        exp_miss = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_do", DO, 32'h0);
        check("reset_ireq", 32'(IREQ), 32'h0);
        check("reset_stall_n", 32'(cache_stall_n), 32'h1);
        check_counters();
        mem_en = 1'b1;

        // Cold miss with a fixed 3-cycle memory latency.
        fixed_delay = 3;
        access(32'h0000_1008, 1'b0, cyc);
        check("cold_latency", 32'(cyc), 32'd6);
        check("cold_do_w2", DO, mem_word(32'h0000_1000, 2));
        fixed_delay = -1;

        // Same-set conflict: C evicts B, A survives.
        access(32'h0000_0010, 1'b0, cyc);
        access(32'h0000_0810, 1'b0, cyc);
        access(32'h0000_0014, 1'b0, cyc);
        access(32'h0000_101C, 1'b0, cyc);
        access(32'h0000_0018, 1'b0, cyc);
        check("conflict_a_hit", 32'(cyc), 32'd1);
        access(32'h0000_0810, 1'b0, cyc);

        // Flush in idle, then flush during a fill.
        flush_idle();
        access(32'h0000_0010, 1'b0, cyc);
        access(32'h0000_2024, 1'b1, cyc);
        access(32'h0000_2028, 1'b0, cyc);

        stray_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 15));
            if (op == 0) begin
                flush_idle();
            end else if (op == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end else begin
                access(rand_addr(), op == 2, cyc);
            end
        end
        stray_en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during a fill; a late IACK must be ignored.
        mem_en   = 1'b0;
        cur_line = 32'hCAFE_0040;
        req      = 1'b1;
        ADDR     = 32'hCAFE_0044;
        @(negedge clk);
        @(negedge clk);
        check("ireq_in_fill", 32'(IREQ), 32'h1);
        rst_n = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        exp_hit  = 0;
        exp_miss = 0;
        check("rst_fill_ireq", 32'(IREQ), 32'h0);
        check("rst_fill_stall_n", 32'(cache_stall_n), 32'h1);
        check("rst_fill_do", DO, 32'h0);
        check_counters();
        late_req++;
        repeat (3) @(negedge clk);
        check("late_iack_ireq", 32'(IREQ), 32'h0);
        check("late_iack_do", DO, 32'h0);
        check_counters();
        mem_en = 1'b1;
        access(32'hCAFE_0044, 1'b0, cyc);
        check("post_reset_refill", 32'(cyc) > 32'd1 ? 32'h1 : 32'h0, 32'h1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
